// File: rtl/cacheline_adaptor.sv
// Bridges the cache's single-transfer line port to a BEATS-beat burst memory port.
// A line read or write is split into BEAT_W-bit beats, lowest beat first.
module cacheline_adaptor #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pmem_address,
  input  logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_read,
  input  logic              pmem_write,
  output logic [LINE_W-1:0] pmem_rdata,
  output logic              pmem_resp,
  output logic [31:0]       address_o,
  output logic              read_o,
  output logic              write_o,
  output logic [BEAT_W-1:0] burst_o,
  input  logic [BEAT_W-1:0] burst_i,
  input  logic              resp_i
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  // Clears the byte-offset bits so the burst starts on a line boundary.
  localparam logic [31:0] LINE_MASK = ~(32'(LINE_W / 8) - 32'd1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_e;

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  next_cnt;
  logic [LINE_W-1:0] line_q;
  logic [LINE_W-1:0] rd_line_next;

  assign next_cnt = cnt + CNT_W'(1);

  // Line buffer with the incoming read beat merged into its slot.
  // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_line_next = line_q;
    rd_line_next[cnt*BEAT_W +: BEAT_W] = burst_i;
  end

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      // NOTE: the line buffer is reset too; it is a register bank, not a RAM, and a known value keeps reads deterministic.
      line_q     <= '0;
      pmem_rdata <= '0;
      pmem_resp  <= 1'b0;
      address_o  <= '0;
      read_o     <= 1'b0;
      write_o    <= 1'b0;
      burst_o    <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          // Writeback has priority over refill when both are requested.
          if (pmem_write) begin
            address_o <= pmem_address & LINE_MASK;
            line_q    <= pmem_wdata;
            burst_o   <= pmem_wdata[BEAT_W-1:0];
            write_o   <= 1'b1;
            state     <= WRITE;
          end else if (pmem_read) begin
            address_o <= pmem_address & LINE_MASK;
            read_o    <= 1'b1;
            state     <= READ;
          end
        end

        READ: begin
          if (resp_i) begin
            line_q <= rd_line_next;
            if (cnt == LAST_BEAT) begin
              pmem_rdata <= rd_line_next;
              read_o     <= 1'b0;
              pmem_resp  <= 1'b1;
              cnt        <= '0;
              state      <= DONE;
            end else begin
              cnt <= next_cnt;
            end
          end
        end

        WRITE: begin
          if (resp_i) begin
            if (cnt == LAST_BEAT) begin
              // burst_o keeps the final beat until the next write is accepted.
              write_o   <= 1'b0;
              pmem_resp <= 1'b1;
              cnt       <= '0;
              state     <= DONE;
            end else begin
              burst_o <= line_q[next_cnt*BEAT_W +: BEAT_W];
              cnt     <= next_cnt;
            end
          end
        end

        DONE: begin
          pmem_resp <= 1'b0;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Bench for cacheline_adaptor: a behavioural burst memory answers with random or
// scripted beat gaps; expected lines are plain beat concatenations.
module tb_cacheline_adaptor;

  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;

  logic              clk;
  logic              rst;
  logic [31:0]       pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic              pmem_read;
  logic              pmem_write;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
  logic [31:0]       address_o;
  logic              read_o;
  logic              write_o;
  logic [BEAT_W-1:0] burst_o;
  logic [BEAT_W-1:0] burst_i;
  logic              resp_i;

  int vectors     = 0;
  int miscompares = 0;

  logic [LINE_W-1:0] last_rline;

  typedef struct packed {
    logic [LINE_W-1:0] wline;
    logic [LINE_W-1:0] rdata;
    logic [31:0]       addr;
    int                beats;
    int                resp_iter;
    bit                resp_one;
    bit                prompt;
    bit                saw_read;
    bit                saw_write;
    bit                idle_at_resp;
  } obs_t;

  cacheline_adaptor #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) dut (
    .clk(clk), .rst(rst),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .address_o(address_o), .read_o(read_o), .write_o(write_o),
    .burst_o(burst_o), .burst_i(burst_i), .resp_i(resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Cache side plus burst memory. Called just after a negedge; drives the request,
  // serves beats while read_o/write_o is high, stops at pmem_resp and returns one
  // negedge later. The memory hands out mem_line beats in order and records burst_o.
  task automatic run_burst(input bit do_write, input bit do_read, input bit keep_read,
                           input logic [31:0] addr, input logic [LINE_W-1:0] wdata,
                           input logic [LINE_W-1:0] mem_line, input int gap_pct,
                           input logic [15:0] pattern, input int pat_len, output obs_t o);
    bit go;
    o = '0;
    pmem_write   = do_write;
    pmem_read    = do_read;
    pmem_address = addr;
    pmem_wdata   = wdata;
    resp_i       = 1'b0;
    @(negedge clk);
    pmem_address = $urandom;
    pmem_wdata   = rand_line();
    o.prompt     = read_o | write_o;
    for (int it = 0; it < 200; it++) begin
      if (pmem_resp) begin
        o.resp_iter    = it;
        o.rdata        = pmem_rdata;
        o.idle_at_resp = !(read_o || write_o);
        resp_i         = 1'b0;
        pmem_write     = 1'b0;
        pmem_read      = keep_read;
        @(negedge clk);
        o.resp_one = !pmem_resp;
        return;
      end
      resp_i  = 1'b0;
      burst_i = {$urandom, $urandom};
      if (read_o || write_o) begin
        o.saw_read  |= read_o;
        o.saw_write |= write_o;
        o.addr       = address_o;
        if (pat_len > 0) go = (it < pat_len) ? pattern[it] : 1'b1;
        else             go = ($urandom_range(99) >= gap_pct);
        if (go) begin
          resp_i = 1'b1;
          if (o.beats < 4) begin
            o.wline[o.beats*BEAT_W +: BEAT_W] = burst_o;
            burst_i = mem_line[o.beats*BEAT_W +: BEAT_W];
          end
          o.beats++;
        end
      end
      @(negedge clk);
    end
    // Cycle budget expired: resp_one stays 0 and the caller flags it.
    resp_i     = 1'b0;
    pmem_write = 1'b0;
    pmem_read  = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    pmem_read = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({pmem_resp, read_o, write_o} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got resp/rd/wr=%b want 000", {pmem_resp, read_o, write_o});
    end
    vectors++;
    if (address_o !== 32'h0 || burst_o !== '0) begin
      miscompares++;
      $display("FAIL reset_addr_burst: got addr=%h burst=%h want 0", address_o, burst_o);
    end
    vectors++;
    if (pmem_rdata !== '0) begin
      miscompares++;
      $display("FAIL reset_rdata: got %h want 0", pmem_rdata);
    end
    pmem_read = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read();
    obs_t o;
    logic [LINE_W-1:0] exp;
    exp = {64'h4444444444444444, 64'h3333333333333333,
           64'h2222222222222222, 64'h1111111111111111};
    run_burst(1'b0, 1'b1, 1'b0, 32'h0000_1234, '0, exp, 0, 16'h0, 0, o);
    vectors++;
    if (o.addr !== 32'h0000_1220) begin
      miscompares++;
      $display("FAIL read_addr: got %h want 00001220", o.addr);
    end
    vectors++;
    if (o.rdata !== exp) begin
      miscompares++;
      $display("FAIL read_line: got %h want %h", o.rdata, exp);
    end
    vectors++;
    if (!o.prompt || o.resp_iter != 4 || !o.resp_one) begin
      miscompares++;
      $display("FAIL read_timing: got prompt=%0b resp_at=%0d one=%0b want 1,4,1",
               o.prompt, o.resp_iter, o.resp_one);
    end
    @(negedge clk);
    vectors++;
    if (pmem_rdata !== exp) begin
      miscompares++;
      $display("FAIL read_hold: got %h want %h", pmem_rdata, exp);
    end
    last_rline = exp;
  endtask

  task automatic test_write();
    obs_t o;
    logic [LINE_W-1:0] w;
    w = {64'hDDDDDDDDDDDDDDDD, 64'hCCCCCCCCCCCCCCCC,
         64'hBBBBBBBBBBBBBBBB, 64'hAAAAAAAAAAAAAAAA};
    run_burst(1'b1, 1'b0, 1'b0, 32'h0000_0400, w, rand_line(), 0, 16'h0, 0, o);
    vectors++;
    if (o.wline !== w || o.beats != 4) begin
      miscompares++;
      $display("FAIL write_beats: got %h (%0d beats) want %h (4 beats)", o.wline, o.beats, w);
    end
    vectors++;
    if (!o.idle_at_resp || o.resp_iter != 4 || !o.resp_one) begin
      miscompares++;
      $display("FAIL write_timing: got idle=%0b resp_at=%0d one=%0b want 1,4,1",
               o.idle_at_resp, o.resp_iter, o.resp_one);
    end
    vectors++;
    if (burst_o !== w[255:192] || pmem_rdata !== last_rline) begin
      miscompares++;
      $display("FAIL write_hold: got burst=%h rdata=%h want burst=%h rdata=%h",
               burst_o, pmem_rdata, w[255:192], last_rline);
    end
  endtask

  task automatic test_gapped_read();
    obs_t o;
    logic [LINE_W-1:0] exp;
    exp = {64'h4444444444444444, 64'h3333333333333333,
           64'h2222222222222222, 64'h1111111111111111};
    // resp_i sequence 1,0,0,1,1,0,1 (first cycle in bit 0)
    run_burst(1'b0, 1'b1, 1'b0, $urandom, '0, exp, 0, 16'b1011001, 7, o);
    vectors++;
    if (o.rdata !== exp) begin
      miscompares++;
      $display("FAIL gap_line: got %h want %h", o.rdata, exp);
    end
    vectors++;
    if (o.beats != 4 || o.resp_iter != 7 || !o.resp_one) begin
      miscompares++;
      $display("FAIL gap_timing: got beats=%0d resp_at=%0d one=%0b want 4,7,1",
               o.beats, o.resp_iter, o.resp_one);
    end
    last_rline = exp;
  endtask

  task automatic test_both_requests();
    obs_t o;
    logic [LINE_W-1:0] w, r;
    w = rand_line();
    r = rand_line();
    run_burst(1'b1, 1'b1, 1'b1, 32'h8000_0047, w, r, 20, 16'h0, 0, o);
    vectors++;
    if (!o.saw_write || o.saw_read || o.wline !== w || !o.resp_one) begin
      miscompares++;
      $display("FAIL both_write_first: got wr=%0b rd=%0b one=%0b line=%h want 1,0,1 line=%h",
               o.saw_write, o.saw_read, o.resp_one, o.wline, w);
    end
    run_burst(1'b0, 1'b1, 1'b0, 32'h8000_0047, '0, r, 20, 16'h0, 0, o);
    vectors++;
    if (!o.saw_read || o.saw_write || o.rdata !== r || o.addr !== 32'h8000_0040) begin
      miscompares++;
      $display("FAIL both_read_after: got rd=%0b wr=%0b addr=%h line=%h want 1,0 80000040 line=%h",
               o.saw_read, o.saw_write, o.addr, o.rdata, r);
    end
    last_rline = r;
  endtask

  task automatic test_reset_midburst();
    obs_t o;
    logic [LINE_W-1:0] r;
    bit bad;
    r = rand_line();
    pmem_read    = 1'b1;
    pmem_address = 32'h0000_5560;
    @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      resp_i  = 1'b1;
      burst_i = r[b*BEAT_W +: BEAT_W];
      @(negedge clk);
    end
    resp_i    = 1'b0;
    pmem_read = 1'b0;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({pmem_resp, read_o, write_o} !== 3'b000 || address_o !== 32'h0 ||
        burst_o !== '0 || pmem_rdata !== '0) begin
      miscompares++;
      $display("FAIL midburst_reset: got resp/rd/wr=%b addr=%h rdata=%h want all 0",
               {pmem_resp, read_o, write_o}, address_o, pmem_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bad |= (pmem_resp !== 1'b0) || (read_o !== 1'b0);
      @(negedge clk);
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL midburst_abandon: got activity after reset want none");
    end
    run_burst(1'b0, 1'b1, 1'b0, 32'h0000_5560, '0, r, 30, 16'h0, 0, o);
    vectors++;
    if (o.rdata !== r || o.beats != 4 || !o.resp_one) begin
      miscompares++;
      $display("FAIL post_reset_read: got beats=%0d one=%0b line=%h want 4,1 line=%h",
               o.beats, o.resp_one, o.rdata, r);
    end
    last_rline = r;
  endtask

  task automatic test_back_to_back();
    obs_t ow, orr;
    logic [LINE_W-1:0] w, r;
    int extra;
    w = rand_line();
    r = rand_line();
    run_burst(1'b1, 1'b0, 1'b0, 32'h0001_0020, w, rand_line(), 25, 16'h0, 0, ow);
    run_burst(1'b0, 1'b1, 1'b0, 32'h0002_00A0, '0, r, 25, 16'h0, 0, orr);
    vectors++;
    if (ow.wline !== w || ow.beats != 4 || !ow.resp_one) begin
      miscompares++;
      $display("FAIL b2b_writeback: got beats=%0d one=%0b line=%h want 4,1 line=%h",
               ow.beats, ow.resp_one, ow.wline, w);
    end
    vectors++;
    if (orr.rdata !== r || orr.beats != 4 || !orr.resp_one || orr.addr !== 32'h0002_00A0) begin
      miscompares++;
      $display("FAIL b2b_refill: got beats=%0d one=%0b addr=%h line=%h want 4,1 000200a0 line=%h",
               orr.beats, orr.resp_one, orr.addr, orr.rdata, r);
    end
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      if (read_o || write_o || pmem_resp) extra++;
      @(negedge clk);
    end
    vectors++;
    if (extra != 0 || pmem_rdata !== r) begin
      miscompares++;
      $display("FAIL b2b_quiet: got %0d busy cycles rdata=%h want 0 rdata=%h", extra, pmem_rdata, r);
    end
    last_rline = r;
  endtask

  task automatic test_random();
    obs_t o;
    logic [LINE_W-1:0] w, r;
    logic [31:0] a;
    bit is_wr;
    for (int n = 0; n < 24; n++) begin
      is_wr = bit'($urandom_range(1));
      a = $urandom;
      w = rand_line();
      r = rand_line();
      run_burst(is_wr, !is_wr, 1'b0, a, w, r, $urandom_range(70), 16'h0, 0, o);
      vectors++;
      if (!o.resp_one || o.beats != 4 || o.addr !== {a[31:5], 5'b0}) begin
        miscompares++;
        $display("FAIL rand_proto[%0d]: got one=%0b beats=%0d addr=%h want 1,4,%h",
                 n, o.resp_one, o.beats, o.addr, {a[31:5], 5'b0});
      end
      if (!is_wr) last_rline = r;
      vectors++;
      if ((is_wr ? o.wline : o.rdata) !== (is_wr ? w : r) || pmem_rdata !== last_rline) begin
        miscompares++;
        $display("FAIL rand_data[%0d]: got %h want %h (wr=%0b)",
                 n, is_wr ? o.wline : o.rdata, is_wr ? w : r, is_wr);
      end
      repeat ($urandom_range(2)) @(negedge clk);
    end
  endtask

  initial begin
    rst          = 1'b1;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    burst_i      = '0;
    resp_i       = 1'b0;
    last_rline   = '0;
    test_reset();
    test_read();
    test_write();
    test_gapped_read();
    test_both_requests();
    test_reset_midburst();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
